div_seq: RTL and testbench

- Multi-cycle sequencer for the EX-stage integer divide resource (DIV/DIVU).
- Runs a 32-iteration radix-2 restoring divide, one iteration per cycle.
- Drives a stall request into the pipeline stall controller while the divide is busy.
- Returns {remainder, quotient} for the HI/LO write in a single ready cycle.

---
 rtl/div_seq_pkg.sv | 25 ++
 rtl/div_seq_iter_step.sv | 41 ++++
 rtl/div_seq.sv | 154 +++++++++++++++
 tb/tb_div_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the EX-stage integer divide sequencer:
//   - divide FSM state encodings (2 bits)
//   - width of the {remainder, quotient} result bus
//   - bit positions of the divide controls inside the ID_TO_EX control bus
// -----------------------------------------------------------------------------
package div_seq_pkg;

    localparam int DIV_DW           = 32;
    localparam int DIV_RESULT_BUS_W = 2 * DIV_DW;

    // Divide control bits carried in the ID_TO_EX pipeline bus.
    localparam int ID_TO_EX_DIV_START_BIT  = 0;
    localparam int ID_TO_EX_DIV_SIGNED_BIT = 1;
    localparam int ID_TO_EX_DIV_ANNUL_BIT  = 2;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_seq_iter_step.sv
// -----------------------------------------------------------------------------
// div_iter_step
// One radix-2 restoring-divide iteration, purely combinational.
// The working value is {partial remainder (DW+1 bits), dividend/quotient (DW)}.
// It is shifted left by one, then the divisor is trial-subtracted from the
// upper DW+1 bits. A non-negative difference is kept and a 1 is shifted into
// the quotient; otherwise the shifted value is kept and a 0 enters.
//
// Ports:
//   divisor   in  DW        divisor magnitude
//   work_in   in  2*DW+1    working value before the iteration
//   work_out  out 2*DW+1    working value after the iteration
// -----------------------------------------------------------------------------
module div_iter_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   divisor,
    input  logic [2*DW:0]   work_in,
    output logic [2*DW:0]   work_out
);

    logic [2*DW:0] shifted;
    logic [DW+1:0] diff;
    logic          unused_work_msb;

    // The partial remainder is always below the divisor, so the top bit of
    // the working value is zero going into an iteration and can be dropped.
    assign unused_work_msb = work_in[2*DW];
    assign shifted         = {work_in[2*DW-1:0], 1'b0};

    // One extra bit so the borrow shows up as diff[DW+1].
    assign diff = {1'b0, shifted[2*DW:DW]} - {2'b00, divisor};

    always_comb begin
        work_out = shifted;
        if (!diff[DW+1]) begin
            work_out = {diff[DW:0], shifted[DW-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle sequencer for the EX-stage DIV/DIVU resource. Runs a DW-step
// restoring divide on operand magnitudes, one step per clock, then applies
// the sign fix-up and presents {remainder, quotient} for the HI/LO write.
//
// Handshake: start_i is a level request held by EX until it sees ready_o.
// ready_o is high for as long as start_i stays high after completion (a
// stalled pipeline keeps the result stable); start_i low in the ready cycle
// returns the unit to FREE. stallreq_o = start_i & ~ready_o holds the
// pipeline while a request is outstanding. annul_i aborts any divide and
// blocks acceptance in FREE.
//
// Ports:
//   clk         in   1      clock, rising edge
//   resetn      in   1      asynchronous active-low reset
//   start_i     in   1      divide request (held until ready_o)
//   signed_i    in   1      1 = DIV (two's complement), 0 = DIVU
//   annul_i     in   1      flush, aborts a divide in progress
//   opdata1_i   in   DW     dividend
//   opdata2_i   in   DW     divisor
//   result_o    out  2*DW   {remainder, quotient}, valid while ready_o=1
//   ready_o     out  1      result valid
//   stallreq_o  out  1      stall request to the pipeline controller
//   state_o     out  2      current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              annul_i,
    input  logic [DW-1:0]     opdata1_i,
    input  logic [DW-1:0]     opdata2_i,
    output logic [2*DW-1:0]   result_o,
    output logic              ready_o,
    output logic              stallreq_o,
    output div_state_t        state_o
);

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [2*DW:0] work;
    logic [2*DW:0] work_next;
    logic [DW-1:0] divisor_mag;
    logic          neg_quot;
    logic          neg_rem;

    logic [DW-1:0] dividend_mag_in;
    logic [DW-1:0] divisor_mag_in;
    logic [DW-1:0] quot_fix;
    logic [DW-1:0] rem_fix;
    logic          unused_rem_msb;

    // Magnitudes at accept. -x of the most negative value is itself, which
    // read as unsigned is the correct magnitude 2^(DW-1).
    assign dividend_mag_in = (signed_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
    assign divisor_mag_in  = (signed_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;

    div_iter_step #(
        .DW (DW)
    ) u_iter_step (
        .divisor  (divisor_mag),
        .work_in  (work),
        .work_out (work_next)
    );

    // After DW steps: quotient in the low DW bits, remainder above it. The
    // remainder is below the divisor, so its extra top bit is always zero.
    assign unused_rem_msb = work[2*DW];
    assign quot_fix = neg_quot ? -work[DW-1:0]    : work[DW-1:0];
    assign rem_fix  = neg_rem  ? -work[2*DW-1:DW] : work[2*DW-1:DW];

    assign stallreq_o = start_i & ~ready_o;
    assign state_o    = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= DIV_FREE;
            cnt         <= '0;
            work        <= '0;
            divisor_mag <= '0;
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
            result_o    <= '0;
            ready_o     <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= DIV_BYZERO;
                        end else begin
                            // Sign decisions are fixed at accept so the
                            // operands may change while the divide runs.
                            neg_quot    <= signed_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                            neg_rem     <= signed_i & opdata1_i[DW-1];
                            divisor_mag <= divisor_mag_in;
                            work        <= {{(DW+1){1'b0}}, dividend_mag_in};
                            cnt         <= '0;
                            state       <= DIV_ON;
                        end
                    end
                end

                DIV_BYZERO: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= DIV_END;
                    end
                end

                DIV_ON: begin
                    if (annul_i) begin
                        cnt   <= '0;
                        state <= DIV_FREE;
                    end else if (cnt != CW'(DW)) begin
                        work <= work_next;
                        cnt  <= cnt + CW'(1);
                    end else begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                        state    <= DIV_END;
                    end
                end

                DIV_END: begin
                    // Stay while EX still holds start_i (downstream stall);
                    // the held request never re-launches a divide.
                    if (annul_i || !start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= DIV_FREE;
                    end
                end

                default: begin
                    state <= DIV_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Directed-vector bench for div_seq. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Cycle 0 is the cycle
// in which start_i is first seen high while the unit is FREE.
// -----------------------------------------------------------------------------
module tb_div_seq;
    import div_seq_pkg::*;

    localparam int DW = 32;
    localparam int CW = 6;

    // ---------------- clock / reset ----------------
    logic            clk       = 1'b0;
    logic            resetn    = 1'b0;
    logic            start_i   = 1'b0;
    logic            signed_i  = 1'b0;
    logic            annul_i   = 1'b0;
    logic [DW-1:0]   opdata1_i = '0;
    logic [DW-1:0]   opdata2_i = '0;
    logic [2*DW-1:0] result_o;
    logic            ready_o;
    logic            stallreq_o;
    div_state_t      state_o;

    always #5 clk = ~clk;

    div_seq #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .annul_i    (annul_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o),
        .state_o    (state_o)
    );

    // ---------------- scoreboard ----------------
    int              n_vec = 0;
    int              n_err = 0;
    logic [2*DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called in cycle 0 (start_i already high). Waits for ready_o, checks
    // latency, stall window, result, hold in END, and the return to FREE.
    task automatic wait_result(input string tag, input int exp_lat);
        int              cyc       = 0;
        int              stall_cnt = 0;
        bit              seen      = 1'b0;
        logic [2*DW-1:0] exp;
        exp = exp_q.pop_front();
        while (!seen && cyc <= 100) begin
            @(negedge clk);
            if (ready_o) begin
                seen = 1'b1;
            end else begin
                if (stallreq_o) stall_cnt++;
                cyc++;
            end
        end
        check({tag, "_timeout"},   64'(seen),       64'd1);
        check({tag, "_latency"},   64'(cyc),        64'(exp_lat));
        check({tag, "_stall_cyc"}, 64'(stall_cnt),  64'(exp_lat));
        check({tag, "_stall_rdy"}, 64'(stallreq_o), 64'd0);
        check({tag, "_result"},    result_o,        exp);
        // start_i still held: result must stay put
        @(negedge clk);
        check({tag, "_hold_rdy"},  64'(ready_o),    64'd1);
        check({tag, "_hold_res"},  result_o,        exp);
        @(posedge clk);
        #1 start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drop_rdy"},  64'(ready_o),    64'd0);
        check({tag, "_drop_res"},  result_o,        64'd0);
        check({tag, "_drop_st"},   64'(state_o),    64'(DIV_FREE));
    endtask

    task automatic run_div(input string tag, input bit sgn,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] q, input logic [DW-1:0] r,
                           input int lat);
        exp_q.push_back({r, q});
        @(posedge clk);
        #1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        wait_result(tag, lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ready_cnt;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  64'(ready_o),    64'd0);
        check("rst_result", result_o,        64'd0);
        check("rst_state",  64'(state_o),    64'(DIV_FREE));
        check("rst_stall",  64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // start with annul in FREE: no accept
        @(posedge clk);
        #1;
        opdata1_i = 32'd20;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(negedge clk);
        check("start_annul_state", 64'(state_o), 64'(DIV_FREE));
        check("start_annul_ready", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;

        // main function, directed vectors
        run_div("u100_7",    1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 34);
        run_div("s-7_2",     1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF, 34);
        run_div("s7_-2",     1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 34);
        run_div("s-100_-7",  1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 34);
        run_div("divzero",   1'b0, 32'h12345678,   32'h00000000,   32'h00000000, 32'h00000000, 2);
        run_div("s_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 34);
        run_div("u_max_1",   1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF, 32'h00000000, 34);
        run_div("u_max_64k", 1'b0, 32'hFFFFFFFF,   32'h00010000,   32'h0000FFFF, 32'h0000FFFF, 34);

        // annul in cycle 10
        @(posedge clk);
        #1;
        signed_i  = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("annul_state", 64'(state_o), 64'(DIV_FREE));
        @(posedge clk);
        #1 annul_i = 1'b0;
        ready_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) ready_cnt++;
        end
        check("annul_no_ready", 64'(ready_cnt), 64'd0);
        run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);

        // asynchronous reset mid-divide (cycle 20), then restart
        exp_q.push_back({32'd0, 32'd100});
        @(posedge clk);
        #1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd10;
        start_i   = 1'b1;
        repeat (20) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_state",  64'(state_o), 64'(DIV_FREE));
        check("midrst_ready",  64'(ready_o), 64'd0);
        check("midrst_result", result_o,     64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        wait_result("rst_restart", 34);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
